// File: rtl/dcom_pkg.sv
// Shared definitions for the serial-to-AHB debug bridge: FSM encoding,
// header/status bit positions and the AHB size helper.
package dcom_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LEN    = 4'd1,
    S_ADDR   = 4'd2,
    S_RXDATA = 4'd3,
    S_AHBWR  = 4'd4,
    S_AHBRD  = 4'd5,
    S_TXDATA = 4'd6,
    S_DRAIN  = 4'd7,
    S_TXSTAT = 4'd8
  } state_e;

  localparam int HDR_START = 7;
  localparam int HDR_WRITE = 6;
  localparam int HDR_FIXED = 5;

  localparam int ST_ERR = 0;
  localparam int ST_TMO = 1;

  function automatic logic [2:0] size_of(input int unsigned nbytes);
    case (nbytes)
      32'd1:   size_of = 3'd0;
      32'd2:   size_of = 3'd1;
      32'd4:   size_of = 3'd2;
      32'd8:   size_of = 3'd3;
      default: size_of = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dcom_byte_shift.sv
// N-byte MSB-first shift register with parallel load and a byte counter;
// last_o flags that the byte being shifted now completes the word.
module dcom_byte_shift #(
  parameter int N = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic           load_i,
  input  logic [8*N-1:0] load_val_i,
  input  logic           shift_in_i,
  input  logic [7:0]     byte_i,
  input  logic           shift_out_i,
  output logic [8*N-1:0] q_o,
  output logic           last_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [8*N-1:0] q_q, q_d, shifted_s;
  logic [CW-1:0]  cnt_q, cnt_d;

  assign q_o    = q_q;
  assign last_o = (cnt_q == CW'(N - 1));

  // Next-state: load wins, then counter clear, then a shift in either direction.
  always_comb begin
    shifted_s = q_q << 4'd8;
    if (shift_in_i) begin
      shifted_s[7:0] = byte_i;
    end else begin
      shifted_s[7:0] = 8'h00;
    end
    q_d   = q_q;
    cnt_d = cnt_q;
    if (load_i) begin
      q_d   = load_val_i;
      cnt_d = '0;
    end else if (clr_i) begin
      cnt_d = '0;
    end else if (shift_in_i || shift_out_i) begin
      q_d   = shifted_s;
      cnt_d = last_o ? '0 : cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dcom_burst_bridge.sv
// Serial-to-AHB debug bridge: decodes host packets from the COM byte stream
// into single-beat AHB transfers and returns read data plus a status byte.
module dcom_burst_bridge
  import dcom_pkg::*;
#(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              DataIn,
  input  logic                    DataReady,
  output logic                    Read,
  output logic [7:0]              DataOut,
  output logic                    Write,
  input  logic                    THEmpty,
  output logic                    AhbReq,
  output logic                    AhbWrite,
  output logic [2:0]              AhbSize,
  output logic [8*ADDR_BYTES-1:0] AhbAddr,
  output logic [8*DATA_BYTES-1:0] AhbOut,
  input  logic [8*DATA_BYTES-1:0] AhbIn,
  input  logic                    Okay,
  input  logic                    AhbErr,
  output logic                    Busy
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int WW = $clog2(TIMEOUT + 2);

  state_e         state_q;
  logic           wr_q, fixed_q, write_q;
  logic [7:0]     len_q, status_q, dout_q, st_next_s;
  logic [8:0]     word_q;
  logic [WW-1:0]  wait_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  wd_q, rd_q;
  logic           addr_last_s, wd_last_s, rd_last_s, unused_rd_s;
  logic           in_ahb_s, tmo_s, fail_s, resp_s, last_word_s, tx_ok_s, start_s;

  assign in_ahb_s    = (state_q == S_AHBWR) || (state_q == S_AHBRD);
  assign tmo_s       = (TIMEOUT != 0) && (wait_q == WW'(TIMEOUT));
  assign fail_s      = AhbErr || tmo_s;
  assign resp_s      = Okay || fail_s;
  assign last_word_s = (word_q == {1'b0, len_q});
  assign tx_ok_s     = THEmpty && !write_q;
  assign start_s     = (state_q == S_IDLE) && DataReady && DataIn[HDR_START];
  assign unused_rd_s = ^rd_q;

  assign Read     = DataReady && ((state_q == S_IDLE) || (state_q == S_LEN) ||
                    (state_q == S_ADDR) || (state_q == S_RXDATA) || (state_q == S_DRAIN));
  assign AhbReq   = in_ahb_s && !resp_s;
  assign AhbWrite = wr_q;
  assign AhbSize  = size_of(DATA_BYTES);
  assign AhbAddr  = addr_q;
  assign AhbOut   = wd_q;
  assign DataOut  = dout_q;
  assign Write    = write_q;
  assign Busy     = (state_q != S_IDLE);

  // Sticky status with any error or timeout seen in this cycle folded in.
  always_comb begin
    st_next_s         = status_q;
    st_next_s[ST_ERR] = status_q[ST_ERR] | AhbErr;
    st_next_s[ST_TMO] = status_q[ST_TMO] | tmo_s;
  end

  dcom_byte_shift #(.N(ADDR_BYTES)) u_addr (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (start_s),
    .load_i     (in_ahb_s && Okay && !fail_s && !fixed_q),
    .load_val_i (addr_q + AW'(DATA_BYTES)),
    .shift_in_i ((state_q == S_ADDR) && DataReady),
    .byte_i     (DataIn),
    .shift_out_i(1'b0),
    .q_o        (addr_q),
    .last_o     (addr_last_s)
  );

  // Drained payload also passes through here; AhbOut is only meaningful under AhbReq.
  dcom_byte_shift #(.N(DATA_BYTES)) u_wdata (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (start_s),
    .load_i     (1'b0),
    .load_val_i ({DW{1'b0}}),
    .shift_in_i (((state_q == S_RXDATA) || (state_q == S_DRAIN)) && DataReady),
    .byte_i     (DataIn),
    .shift_out_i(1'b0),
    .q_o        (wd_q),
    .last_o     (wd_last_s)
  );

  dcom_byte_shift #(.N(DATA_BYTES)) u_rdata (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (1'b0),
    .load_i     ((state_q == S_AHBRD) && resp_s),
    .load_val_i (fail_s ? {DW{1'b0}} : AhbIn),
    .shift_in_i (1'b0),
    .byte_i     (8'h00),
    .shift_out_i((state_q == S_TXDATA) && tx_ok_s),
    .q_o        (rd_q),
    .last_o     (rd_last_s)
  );

  // Command FSM with registered transmit outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      fixed_q  <= 1'b0;
      write_q  <= 1'b0;
      len_q    <= 8'h00;
      status_q <= 8'h00;
      dout_q   <= 8'h00;
      word_q   <= 9'd0;
      wait_q   <= '0;
    end else begin
      write_q <= 1'b0;
      wait_q  <= (in_ahb_s && !resp_s) ? wait_q + WW'(1) : '0;
      case (state_q)
        S_IDLE: begin
          if (start_s) begin
            wr_q     <= DataIn[HDR_WRITE];
            fixed_q  <= DataIn[HDR_FIXED];
            status_q <= 8'h00;
            word_q   <= 9'd0;
            state_q  <= S_LEN;
          end
        end
        S_LEN: begin
          if (DataReady) begin
            len_q   <= DataIn;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (DataReady && addr_last_s) begin
            state_q <= wr_q ? S_RXDATA : S_AHBRD;
          end
        end
        S_RXDATA: begin
          if (DataReady && wd_last_s) begin
            state_q <= S_AHBWR;
          end
        end
        S_AHBWR: begin
          if (resp_s) begin
            status_q <= st_next_s;
            if (last_word_s) begin
              state_q <= S_TXSTAT;
            end else begin
              word_q  <= word_q + 9'd1;
              state_q <= fail_s ? S_DRAIN : S_RXDATA;
            end
          end
        end
        S_AHBRD: begin
          if (resp_s) begin
            status_q <= st_next_s;
            state_q  <= S_TXDATA;
          end
        end
        S_TXDATA: begin
          if (tx_ok_s) begin
            write_q <= 1'b1;
            dout_q  <= rd_q[DW-1 -: 8];
            if (rd_last_s) begin
              if (last_word_s) begin
                state_q <= S_TXSTAT;
              end else begin
                // After a failure the emptied shifter supplies the zero filler words.
                word_q  <= word_q + 9'd1;
                state_q <= (status_q != 8'h00) ? S_TXDATA : S_AHBRD;
              end
            end
          end
        end
        S_DRAIN: begin
          if (DataReady && wd_last_s) begin
            if (last_word_s) begin
              state_q <= S_TXSTAT;
            end else begin
              word_q <= word_q + 9'd1;
            end
          end
        end
        S_TXSTAT: begin
          if (tx_ok_s) begin
            write_q <= 1'b1;
            dout_q  <= status_q;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
